// File: rtl/sweep_pkg.sv
// rtl/sweep_pkg.sv - shared state encoding and default width for the sweep controller
package sweep_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        UP   = 2'd1,
        DOWN = 2'd2,
        DONE = 2'd3
    } sweep_state_t;

endpackage

// File: rtl/sweep_counter.sv
// rtl/sweep_counter.sv - WIDTH-bit up/down counter with synchronous load and enable
// Ports: clk, reset (sync, active-high), load/load_val (load has priority),
//        en (step enable), up (1 = increment, 0 = decrement), count (current value).
module sweep_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic             up,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en) begin
            count <= up ? count + ONE : count - ONE;
        end
    end

endmodule

// File: rtl/sweep_ctrl.sv
// rtl/sweep_ctrl.sv - lo->hi->lo sweep sequencer with pass count, abort and start validation
// Ports: clk, reset (sync, active-high), start/abort requests, lo/hi/passes run limits,
//        count (counter value), dir (counting up), busy (sweeping), done/err (one-cycle pulses).
module sweep_ctrl
    import sweep_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] lo,
    input  logic [WIDTH-1:0] hi,
    input  logic [2:0]       passes,
    output logic [WIDTH-1:0] count,
    output logic             dir,
    output logic             busy,
    output logic             done,
    output logic             err
);

    sweep_state_t     state;
    sweep_state_t     state_next;
    logic [WIDTH-1:0] lo_q;
    logic [WIDTH-1:0] hi_q;
    logic [2:0]       passes_q;
    logic [2:0]       pass_cnt;
    logic             err_q;
    logic             accept;
    logic             reject;
    logic             cnt_load;
    logic             cnt_en;
    logic             cnt_up;
    logic             pass_inc;
    logic             last_pass;

    sweep_counter #(.WIDTH(WIDTH)) u_counter (
        .clk      (clk),
        .reset    (reset),
        .load     (cnt_load),
        .load_val (lo),
        .en       (cnt_en),
        .up       (cnt_up),
        .count    (count)
    );

    // passes_q holds the effective pass count (>= 1 while running), so the
    // pass finishing now is the last one when pass_cnt has reached passes_q-1.
    assign last_pass = (pass_cnt == passes_q - 3'd1);
    assign err       = err_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Turning points reuse the counter step: decrementing from hi gives hi-1,
    // incrementing from lo gives lo+1, so only the start needs a load.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        reject     = 1'b0;
        cnt_load   = 1'b0;
        cnt_en     = 1'b0;
        cnt_up     = 1'b1;
        pass_inc   = 1'b0;
        dir        = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (lo < hi) begin
                        accept     = 1'b1;
                        cnt_load   = 1'b1;
                        state_next = UP;
                    end else begin
                        reject = 1'b1;
                    end
                end
            end
            UP: begin
                dir  = 1'b1;
                busy = 1'b1;
                if (abort) begin
                    state_next = IDLE;
                end else if (count == hi_q) begin
                    cnt_en     = 1'b1;
                    cnt_up     = 1'b0;
                    state_next = DOWN;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            DOWN: begin
                busy = 1'b1;
                if (abort) begin
                    state_next = IDLE;
                end else if (count != lo_q) begin
                    cnt_en = 1'b1;
                    cnt_up = 1'b0;
                end else begin
                    pass_inc = 1'b1;
                    if (last_pass) begin
                        state_next = DONE;
                    end else begin
                        cnt_en     = 1'b1;
                        state_next = UP;
                    end
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lo_q     <= '0;
            hi_q     <= '0;
            passes_q <= 3'd0;
            pass_cnt <= 3'd0;
            err_q    <= 1'b0;
        end else begin
            err_q <= reject;
            if (accept) begin
                lo_q     <= lo;
                hi_q     <= hi;
                passes_q <= (passes == 3'd0) ? 3'd1 : passes;
                pass_cnt <= 3'd0;
            end else if (pass_inc) begin
                pass_cnt <= pass_cnt + 3'd1;
            end
        end
    end

endmodule

// File: tb/tb_sweep_ctrl.sv
// tb/tb_sweep_ctrl.sv - table-driven scoreboard bench for sweep_ctrl
module tb_sweep_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       abort;
    logic [3:0] lo;
    logic [3:0] hi;
    logic [2:0] passes;
    logic [3:0] count;
    logic       dir;
    logic       busy;
    logic       done;
    logic       err;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [3:0] count;
        logic       dir;
        logic       busy;
        logic       done;
        logic       err;
    } exp_t;

    typedef struct {
        string      name;
        logic [3:0] lo;
        logic [3:0] hi;
        logic [2:0] passes;
        int         kill_k;
        int         kind;
    } vec_t;

    exp_t       exp_q[$];
    logic [3:0] hold_count;

    sweep_ctrl #(.WIDTH(4)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .abort  (abort),
        .lo     (lo),
        .hi     (hi),
        .passes (passes),
        .count  (count),
        .dir    (dir),
        .busy   (busy),
        .done   (done),
        .err    (err)
    );

    always #5 clk = ~clk;

    function automatic exp_t mk(input int c, input bit d, input bit b, input bit dn, input bit e);
        exp_t x;
        x.count = 4'(c);
        x.dir   = d;
        x.busy  = b;
        x.done  = dn;
        x.err   = e;
        return x;
    endfunction

    task automatic check(input string name, input int k, input exp_t e);
        n_checks++;
        if (count !== e.count || dir !== e.dir || busy !== e.busy || done !== e.done || err !== e.err) begin
            n_errors++;
            $display("FAIL %s cyc=%0d got count=%0d dir=%0b busy=%0b done=%0b err=%0b exp count=%0d dir=%0b busy=%0b done=%0b err=%0b",
                     name, k, count, dir, busy, done, err, e.count, e.dir, e.busy, e.done, e.err);
        end
    endtask

    // Builds the expected per-cycle trace from the sweep definition, then drives
    // start and replays the trace against the DUT one cycle at a time.
    task automatic run(input vec_t v);
        int   pe;
        int   first;
        int   n;
        exp_t e;
        exp_q.delete();
        if (v.lo >= v.hi) begin
            exp_q.push_back(mk(hold_count, 0, 0, 0, 1));
            exp_q.push_back(mk(hold_count, 0, 0, 0, 0));
        end else begin
            pe = (v.passes == 0) ? 1 : int'(v.passes);
            for (int p = 0; p < pe; p++) begin
                first = (p == 0) ? int'(v.lo) : int'(v.lo) + 1;
                for (int c = first; c <= int'(v.hi); c++) exp_q.push_back(mk(c, 1, 1, 0, 0));
                for (int c = int'(v.hi) - 1; c >= int'(v.lo); c--) exp_q.push_back(mk(c, 0, 1, 0, 0));
            end
            exp_q.push_back(mk(v.lo, 0, 0, 1, 0));
            exp_q.push_back(mk(v.lo, 0, 0, 0, 0));
            if (v.kill_k >= 0) begin
                e = exp_q[v.kill_k];
                while (exp_q.size() > v.kill_k + 1) void'(exp_q.pop_back());
                exp_q.push_back(mk((v.kind == 1) ? int'(e.count) : 0, 0, 0, 0, 0));
            end
        end
        hold_count = exp_q[exp_q.size() - 1].count;

        lo     = v.lo;
        hi     = v.hi;
        passes = v.passes;
        start  = 1'b1;
        abort  = 1'($urandom_range(0, 1));
        @(posedge clk);
        #1;
        start = 1'b0;
        abort = 1'b0;

        n = exp_q.size();
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            check(v.name, k, e);
            if (e.busy || e.done) begin
                start  = 1'($urandom_range(0, 1));
                lo     = 4'($urandom);
                hi     = 4'($urandom);
                passes = 3'($urandom);
                abort  = e.done || (k == v.kill_k && v.kind == 1);
                if (k == v.kill_k && v.kind == 2) begin
                    reset = 1'b1;
                    start = 1'b1;
                    lo    = 4'd0;
                    hi    = 4'd9;
                end
            end else begin
                start = 1'b0;
                abort = 1'b1;
            end
            @(posedge clk);
            #1;
            reset = 1'b0;
            start = 1'b0;
            abort = 1'b0;
        end
    endtask

    vec_t vecs[$];

    initial begin
        vecs.push_back('{"basic",       4'd2,  4'd5,  3'd1, -1, 0});
        vecs.push_back('{"equal",       4'd7,  4'd7,  3'd1, -1, 0});
        vecs.push_back('{"full_range",  4'd0,  4'd15, 3'd2, -1, 0});
        vecs.push_back('{"passes_zero", 4'd3,  4'd4,  3'd0, -1, 0});
        vecs.push_back('{"inverted",    4'd9,  4'd3,  3'd1, -1, 0});
        vecs.push_back('{"abort_down",  4'd1,  4'd4,  3'd3,  6, 1});
        vecs.push_back('{"after_abort", 4'd1,  4'd4,  3'd1, -1, 0});
        vecs.push_back('{"reset_up",    4'd1,  4'd6,  3'd1,  2, 2});
        vecs.push_back('{"seven_pass",  4'd0,  4'd1,  3'd7, -1, 0});
        vecs.push_back('{"top_edge",    4'd14, 4'd15, 3'd3, -1, 0});
        vecs.push_back('{"equal_hold",  4'd14, 4'd14, 3'd5, -1, 0});
        vecs.push_back('{"full_seven",  4'd0,  4'd15, 3'd7, -1, 0});

        reset  = 1'b1;
        start  = 1'b1;
        abort  = 1'b1;
        lo     = 4'd2;
        hi     = 4'd8;
        passes = 3'd1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        @(negedge clk);
        check("reset_state", 0, mk(0, 0, 0, 0, 0));
        hold_count = 4'd0;

        foreach (vecs[i]) run(vecs[i]);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/sweep_ctrl.md
SWEEP_CTRL -- requirements
Module: sweep_ctrl

Interface
REQ-001 The block SHALL have one parameter: WIDTH, default 4, counter and limit width in bits.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-004 start  input  1  request a sweep run; sampled only in IDLE.
REQ-005 abort  input  1  terminate an active sweep; sampled only in UP/DOWN.
REQ-006 lo  input  WIDTH  sweep floor; latched on accepted start.
REQ-007 hi  input  WIDTH  sweep ceiling; latched on accepted start.
REQ-008 passes  input  3  number of lo->hi->lo passes; latched on accepted start; 0 treated as 1.
REQ-009 count  output  WIDTH  current counter value.
REQ-010 dir  output  1  1 while state is UP, else 0.
REQ-011 busy  output  1  1 while state is UP or DOWN.
REQ-012 done  output  1  one-cycle pulse on normal completion.
REQ-013 err  output  1  one-cycle pulse when start is rejected.

Function
REQ-014 The FSM SHALL have exactly four states: IDLE, UP, DOWN, DONE.
REQ-015 In IDLE, start=1 with lo<hi SHALL latch lo/hi/passes, clear the pass counter, load count=lo and enter UP on the same edge.
REQ-016 In IDLE, start=1 with lo>=hi SHALL pulse err for one cycle, leave count unchanged and remain in IDLE.
REQ-017 In UP, count<hi SHALL increment count; count==hi SHALL set count=hi-1 and enter DOWN (hi is held for exactly one cycle).
REQ-018 In DOWN, count>lo SHALL decrement count; count==lo SHALL increment the pass counter.
REQ-019 At DOWN with count==lo: if the completed pass is the last, the FSM SHALL enter DONE with count held at lo; otherwise it SHALL set count=lo+1 and enter UP.
REQ-020 DONE SHALL last exactly one cycle with done=1, then return to IDLE; count SHALL hold in DONE and IDLE.
REQ-021 done SHALL rise exactly 2*(hi-lo)*P+1 edges after the edge that accepted start (P = effective passes).
REQ-022 start SHALL be ignored in UP, DOWN and DONE; latched lo/hi/passes SHALL not change mid-run.
REQ-023 abort in UP or DOWN SHALL enter IDLE on the next edge, holding count, with no done pulse; abort SHALL be ignored in IDLE and DONE.
REQ-024 Simultaneous start and abort in IDLE SHALL be treated as start alone.
REQ-025 count SHALL never leave [lo, hi] while busy; no arithmetic wrap SHALL occur, including hi = 2^WIDTH-1 and lo = 0.
REQ-026 err and done SHALL never be asserted in the same cycle.

Reset
REQ-027 reset=1 SHALL, on the next rising edge, force IDLE, count=0, pass counter=0, latched limits=0, and dir/busy/done/err=0, regardless of state.
REQ-028 reset SHALL take priority over start and abort; reset mid-sweep SHALL produce no done pulse.

Structure
REQ-029 Package sweep_pkg SHALL hold the four-state encoding and the default WIDTH constant.
REQ-030 The counter datapath SHALL be a sub-module sweep_counter (WIDTH-bit, synchronous load, enable, up/down select); sweep_ctrl SHALL contain only the FSM, pass counter and limit registers.

Verification
REQ-031 lo=2, hi=5, passes=1, start one cycle -> count 2,3,4,5,4,3,2, then done pulse at edge 7 after acceptance, busy=0 afterwards, count holds 2.
REQ-032 lo=0, hi=15, passes=2 -> count reaches 15 twice and 0 three times, no wrap, done exactly 61 edges after acceptance.
REQ-033 lo=7, hi=7 start -> err pulse one cycle, busy stays 0, count unchanged, no done.
REQ-034 lo=1, hi=4, passes=3, abort asserted at the third DOWN cycle -> IDLE next edge, count holds, done never pulses; new start afterwards runs normally.
REQ-035 reset asserted while in UP with count=3 -> next edge count=0, IDLE, all flags 0; start pulses during run and abort in IDLE have no effect.
REQ-036 passes=0, lo=3, hi=4 -> behaves as one pass: count 3,4,3, done at edge 3 after acceptance.
